// File: rtl/irq_edge_collector_pkg.sv
// ============================================================================
// Module   : irq_collector_pkg
// Purpose  : Shared FSM state encoding and pending-vector index mapping for
//            the edge interrupt collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_e;

    // Pending/enable/ovf vectors: rising events low half, falling events high half
    function automatic int rise_idx(input int ch);
        return ch;
    endfunction

    function automatic int fall_idx(input int num_ch, input int ch);
        return num_ch + ch;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_edge_collector_if.sv
// ============================================================================
// Module   : irq_edge_collector_if
// Purpose  : Event, control and status bundle between edge sources/register
//            block (master) and the interrupt collector (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface irq_edge_collector_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0]       r_edge;
    logic [NUM_CH-1:0]       f_edge;
    logic [2*NUM_CH-1:0]     irq_en;
    logic                    clr_valid;
    logic [2*NUM_CH-1:0]     clr_mask;
    logic [NUM_CH-1:0]       cnt_clr;
    logic [2*NUM_CH-1:0]     pending;
    logic [2*NUM_CH-1:0]     ovf;
    logic [NUM_CH*CNT_W-1:0] evt_cnt;
    logic                    irq;

    modport master (
        output r_edge, f_edge, irq_en, clr_valid, clr_mask, cnt_clr,
        input  pending, ovf, evt_cnt, irq
    );

    modport slave (
        input  r_edge, f_edge, irq_en, clr_valid, clr_mask, cnt_clr,
        output pending, ovf, evt_cnt, irq
    );
endinterface

`default_nettype wire

// File: rtl/irq_edge_collector_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Per-channel event counter, adds 0/1/2 per cycle, saturates at
//            all-ones; a clear loads the same-cycle increment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [1:0]       inc,
    input  wire logic             clr,
    output logic      [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W:0]   w_sum;

    always_comb begin
        w_sum = {1'b0, r_cnt} + (CNT_W+1)'(inc);
        if (clr) begin
            w_cnt_nxt = CNT_W'(inc);
        end else if (w_sum[CNT_W]) begin
            w_cnt_nxt = '1;
        end else begin
            w_cnt_nxt = w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign cnt = r_cnt;
endmodule

`default_nettype wire

// File: rtl/irq_edge_collector.sv
// ============================================================================
// Module   : irq_edge_collector
// Purpose  : Latches edge pulses into sticky pending/overflow bits, counts
//            events per channel and drives a level irq with holdoff.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_edge_collector
    import irq_collector_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 8,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    irq_edge_collector_if.slave bus
);
    localparam int c_NB     = 2 * NUM_CH;
    localparam int c_HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD =
        c_HOLD_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    logic [c_NB-1:0]               w_evt;
    logic [c_NB-1:0]               w_clr;
    logic [c_NB-1:0]               w_pending_nxt;
    logic [c_NB-1:0]               w_ovf_nxt;
    logic [c_NB-1:0]               r_pending;
    logic [c_NB-1:0]               r_ovf;
    logic                          w_act;
    irq_state_e                    r_state;
    irq_state_e                    w_state_nxt;
    logic [c_HOLD_W-1:0]           r_hold_cnt;
    logic [c_HOLD_W-1:0]           w_hold_cnt_nxt;
    logic                          r_irq;
    logic                          w_irq_nxt;
    logic [NUM_CH-1:0][CNT_W-1:0]  w_evt_cnt;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_evt[rise_idx(i)]         = bus.r_edge[i];
            assign w_evt[fall_idx(NUM_CH, i)] = bus.f_edge[i];

            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   ({1'b0, bus.r_edge[i]} + {1'b0, bus.f_edge[i]}),
                .clr   (bus.cnt_clr[i]),
                .cnt   (w_evt_cnt[i])
            );
        end
    endgenerate

    // A new event outranks a same-cycle clear; a cleared bit never overflows
    assign w_clr         = bus.clr_valid ? bus.clr_mask : '0;
    assign w_pending_nxt = (r_pending & ~w_clr) | w_evt;
    assign w_ovf_nxt     = (r_ovf & ~w_clr) | (w_evt & r_pending & ~w_clr);
    assign w_act         = |(r_pending & bus.irq_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_ovf     <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        case (r_state)
            IDLE: begin
                if (w_act) w_state_nxt = ASSERT;
            end
            ASSERT: begin
                if (!w_act) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt    = HOLDOFF;
                        w_hold_cnt_nxt = c_HOLD_LOAD;
                    end
                end
            end
            HOLDOFF: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - c_HOLD_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // irq is the registered image of the ASSERT state
        w_irq_nxt = (r_state == ASSERT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_irq      <= w_irq_nxt;
        end
    end

    assign bus.pending = r_pending;
    assign bus.ovf     = r_ovf;
    assign bus.evt_cnt = w_evt_cnt;
    assign bus.irq     = r_irq;
endmodule

`default_nettype wire

// File: tb/tb_irq_edge_collector.sv
// ============================================================================
// Module   : tb_irq_edge_collector
// Purpose  : Directed self-checking bench for irq_edge_collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_edge_collector;
    localparam int NUM_CH         = 4;
    localparam int CNT_W          = 8;
    localparam int HOLDOFF_CYCLES = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    irq_edge_collector_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    irq_edge_collector #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return bus.evt_cnt[ch*CNT_W +: CNT_W];
    endfunction

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.r_edge    = '0;
        bus.f_edge    = '0;
        bus.irq_en    = '0;
        bus.clr_valid = 1'b0;
        bus.clr_mask  = '0;
        bus.cnt_clr   = '0;
        tick();
        tick();
        n_checks++;
        if (bus.pending !== 8'h00 || bus.ovf !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_flags: pending=%h ovf=%h required 00 00", bus.pending, bus.ovf);
        end
        n_checks++;
        if (bus.evt_cnt !== 32'h0 || bus.irq !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_cnt_irq: evt_cnt=%h irq=%b required 0 0", bus.evt_cnt, bus.irq);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bus.irq_en = 8'hFF;
        bus.r_edge = 4'h1;
        tick();
        bus.r_edge = 4'h0;
        n_checks++;
        if (bus.pending !== 8'h01 || bus.ovf !== 8'h00) begin
            n_errors++;
            $display("FAIL basic_pending: pending=%h ovf=%h required 01 00", bus.pending, bus.ovf);
        end
        n_checks++;
        if (cnt_of(0) !== 8'd1) begin
            n_errors++;
            $display("FAIL basic_cnt: ch0=%0d required 1", cnt_of(0));
        end
        n_checks++;
        if (bus.irq !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_irq_k: irq=%b required 0", bus.irq);
        end
        tick();
        n_checks++;
        if (bus.irq !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_irq_k1: irq=%b required 0", bus.irq);
        end
        tick();
        n_checks++;
        if (bus.irq !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_irq_k2: irq=%b required 1", bus.irq);
        end
    endtask

    task automatic test_ovf_clear();
        bus.r_edge = 4'h1;
        tick();
        bus.r_edge = 4'h0;
        n_checks++;
        if (bus.ovf !== 8'h01 || cnt_of(0) !== 8'd2) begin
            n_errors++;
            $display("FAIL ovf_set: ovf=%h ch0=%0d required 01 2", bus.ovf, cnt_of(0));
        end
        bus.clr_valid = 1'b1;
        bus.clr_mask  = 8'h01;
        tick();
        bus.clr_valid = 1'b0;
        bus.clr_mask  = 8'h00;
        n_checks++;
        if (bus.pending !== 8'h00 || bus.ovf !== 8'h00) begin
            n_errors++;
            $display("FAIL ovf_clear: pending=%h ovf=%h required 00 00", bus.pending, bus.ovf);
        end
        tick();
        n_checks++;
        if (bus.irq !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_irq_c1: irq=%b required 1", bus.irq);
        end
        for (int t = 0; t < HOLDOFF_CYCLES; t++) begin
            tick();
            n_checks++;
            if (bus.irq !== 1'b0) begin
                n_errors++;
                $display("FAIL clear_irq_low[%0d]: irq=%b required 0", t, bus.irq);
            end
        end
    endtask

    task automatic test_masked();
        bus.irq_en = 8'h00;
        bus.f_edge = 4'h4;
        tick();
        bus.f_edge = 4'h0;
        n_checks++;
        if (bus.pending !== 8'h40) begin
            n_errors++;
            $display("FAIL masked_pending: pending=%h required 40", bus.pending);
        end
        tick();
        tick();
        n_checks++;
        if (bus.irq !== 1'b0) begin
            n_errors++;
            $display("FAIL masked_irq: irq=%b required 0", bus.irq);
        end
        bus.irq_en = 8'h40;
        tick();
        n_checks++;
        if (bus.irq !== 1'b0) begin
            n_errors++;
            $display("FAIL unmask_irq_1: irq=%b required 0", bus.irq);
        end
        tick();
        n_checks++;
        if (bus.irq !== 1'b1) begin
            n_errors++;
            $display("FAIL unmask_irq_2: irq=%b required 1", bus.irq);
        end
    endtask

    task automatic test_set_clear_same_cycle();
        bus.f_edge = 4'h2;
        tick();
        bus.f_edge = 4'h0;
        n_checks++;
        if (bus.pending !== 8'h60) begin
            n_errors++;
            $display("FAIL same_pre: pending=%h required 60", bus.pending);
        end
        bus.f_edge    = 4'h2;
        bus.clr_valid = 1'b1;
        bus.clr_mask  = 8'h20;
        tick();
        bus.f_edge    = 4'h0;
        bus.clr_valid = 1'b0;
        bus.clr_mask  = 8'h00;
        n_checks++;
        if (bus.pending !== 8'h60 || bus.ovf !== 8'h00) begin
            n_errors++;
            $display("FAIL same_cycle: pending=%h ovf=%h required 60 00", bus.pending, bus.ovf);
        end
        n_checks++;
        if (cnt_of(1) !== 8'd2 || cnt_of(2) !== 8'd1) begin
            n_errors++;
            $display("FAIL same_cnt: ch1=%0d ch2=%0d required 2 1", cnt_of(1), cnt_of(2));
        end
        tick();
        n_checks++;
        if (bus.irq !== 1'b1) begin
            n_errors++;
            $display("FAIL same_irq: irq=%b required 1", bus.irq);
        end
    endtask

    task automatic test_saturation();
        bus.r_edge = 4'h8;
        for (int i = 0; i < 300; i++) tick();
        bus.r_edge = 4'h0;
        n_checks++;
        if (cnt_of(3) !== 8'd255) begin
            n_errors++;
            $display("FAIL sat_cnt: ch3=%0d required 255", cnt_of(3));
        end
        bus.cnt_clr = 4'h8;
        bus.r_edge  = 4'h8;
        bus.f_edge  = 4'h8;
        tick();
        bus.cnt_clr = 4'h0;
        bus.r_edge  = 4'h0;
        bus.f_edge  = 4'h0;
        n_checks++;
        if (cnt_of(3) !== 8'd2 || cnt_of(0) !== 8'd2) begin
            n_errors++;
            $display("FAIL clr_load: ch3=%0d ch0=%0d required 2 2", cnt_of(3), cnt_of(0));
        end
        n_checks++;
        if (bus.pending !== 8'hE8 || bus.ovf !== 8'h08) begin
            n_errors++;
            $display("FAIL sat_flags: pending=%h ovf=%h required e8 08", bus.pending, bus.ovf);
        end
    endtask

    task automatic test_holdoff();
        logic exp_irq;
        bus.irq_en    = 8'hFF;
        bus.clr_valid = 1'b1;
        bus.clr_mask  = 8'hFF;
        tick();
        bus.clr_valid = 1'b0;
        bus.clr_mask  = 8'h00;
        n_checks++;
        if (bus.pending !== 8'h00) begin
            n_errors++;
            $display("FAIL hold_clear: pending=%h required 00", bus.pending);
        end
        // Clear edge is t=0; irq falls at t=2, event at t=3, re-asserts at t=19
        for (int t = 1; t <= 19; t++) begin
            if (t == 3) bus.r_edge = 4'h2;
            tick();
            bus.r_edge = 4'h0;
            exp_irq = (t == 1 || t == 19);
            n_checks++;
            if (bus.irq !== exp_irq) begin
                n_errors++;
                $display("FAIL holdoff_irq[t=%0d]: irq=%b required %b", t, bus.irq, exp_irq);
            end
        end
        n_checks++;
        if (bus.pending !== 8'h02) begin
            n_errors++;
            $display("FAIL hold_pending: pending=%h required 02", bus.pending);
        end
    endtask

    task automatic test_reset_mid_holdoff();
        bus.clr_valid = 1'b1;
        bus.clr_mask  = 8'hFF;
        tick();
        bus.clr_valid = 1'b0;
        bus.clr_mask  = 8'h00;
        tick();
        tick();
        bus.f_edge = 4'h1;
        tick();
        tick();
        bus.f_edge = 4'h0;
        n_checks++;
        if (bus.pending !== 8'h10 || bus.ovf !== 8'h10 || bus.irq !== 1'b0) begin
            n_errors++;
            $display("FAIL pre_reset: pending=%h ovf=%h irq=%b required 10 10 0",
                     bus.pending, bus.ovf, bus.irq);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.pending !== 8'h00 || bus.ovf !== 8'h00 || bus.evt_cnt !== 32'h0 || bus.irq !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: pending=%h ovf=%h evt_cnt=%h irq=%b required all 0",
                     bus.pending, bus.ovf, bus.evt_cnt, bus.irq);
        end
        bus.r_edge = 4'h1;
        tick();
        bus.r_edge = 4'h0;
        n_checks++;
        if (bus.pending !== 8'h00 || cnt_of(0) !== 8'd0) begin
            n_errors++;
            $display("FAIL pulse_in_reset: pending=%h ch0=%0d required 00 0", bus.pending, cnt_of(0));
        end
        rst_n = 1'b1;
        tick();
        bus.r_edge = 4'h1;
        tick();
        bus.r_edge = 4'h0;
        n_checks++;
        if (bus.pending !== 8'h01 || cnt_of(0) !== 8'd1) begin
            n_errors++;
            $display("FAIL post_reset_evt: pending=%h ch0=%0d required 01 1", bus.pending, cnt_of(0));
        end
        tick();
        tick();
        n_checks++;
        if (bus.irq !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_irq: irq=%b required 1", bus.irq);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_ovf_clear();
        test_masked();
        test_set_clear_same_cycle();
        test_saturation();
        test_holdoff();
        test_reset_mid_holdoff();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/irq_edge_collector.md
Name: irq_edge_collector

Overview:
Downstream consumer of edge_detect. Takes per-channel r_edge/f_edge single-cycle pulses, latches them into sticky pending/overflow bits, counts events per channel, and drives one level interrupt to the PS (Kria GIC) through a holdoff state machine. Software clears pending bits via write-1-to-clear pulses from the AXI-Lite register block.

Parameters:
NUM_CH, 4, number of edge_detect channels feeding this block
CNT_W, 8, width of per-channel saturating event counters
HOLDOFF_CYCLES, 16, irq deassert time after all enabled pending bits are cleared (0 = no holdoff)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
r_edge  in  NUM_CH  rising-edge pulses, one bit per channel, from edge_detect
f_edge  in  NUM_CH  falling-edge pulses, one bit per channel, from edge_detect
irq_en  in  2*NUM_CH  enable mask, [NUM_CH-1:0] rising, [2*NUM_CH-1:NUM_CH] falling
clr_valid  in  1  W1C strobe
clr_mask  in  2*NUM_CH  bits to clear in pending and ovf when clr_valid=1
cnt_clr  in  NUM_CH  per-channel counter clear pulse
pending  out  2*NUM_CH  sticky event bits, same layout as irq_en
ovf  out  2*NUM_CH  sticky: event arrived while its pending bit was already 1
evt_cnt  out  NUM_CH*CNT_W  per-channel count of rising+falling events, channel i at [i*CNT_W +: CNT_W]
irq  out  1  level interrupt to PS, registered

Behaviour:
- Reset: all outputs 0; FSM in IDLE; holdoff counter 0.
- Pending: event pulse sampled at posedge k sets its bit, visible after k. Bits latch regardless of irq_en; irq_en only gates irq.
- Set and clear of the same bit in one cycle: set wins, bit stays 1 and ovf does not set.
- ovf[b] sets when event b arrives, pending[b]=1, and b is not being cleared that cycle. ovf is cleared only by clr_mask with clr_valid.
- evt_cnt[i] increments by 1 for r_edge[i] or f_edge[i], and by 2 if both are high in one cycle. It saturates at 2^CNT_W-1 with no wrap.
- cnt_clr[i] together with an event in the same cycle loads the event increment (1 or 2), not 0.
- act = |(pending & irq_en), using registered pending.
- FSM states:
  - IDLE: irq=0. act=1 -> ASSERT. An event at posedge k gives irq=1 after posedge k+2.
  - ASSERT: irq=1. act=0 -> HOLDOFF, loading counter with HOLDOFF_CYCLES-1. If HOLDOFF_CYCLES=0, go directly to IDLE.
  - HOLDOFF: irq=0 for exactly HOLDOFF_CYCLES cycles regardless of act, then -> IDLE. IDLE re-asserts next cycle if act=1.
- Clearing irq_en bits while in ASSERT drops act, so the FSM enters HOLDOFF. Pending bits are retained.
- Reset asserted mid-operation: immediate asynchronous return to reset values. Pulses during reset are lost.

Decomposition:
- Package irq_collector_pkg: FSM state enum (IDLE, ASSERT, HOLDOFF) and a localparam helper for pending-index mapping (rise idx = ch, fall idx = NUM_CH+ch).
- Sub-module sat_counter (CNT_W, inc amount 0/1/2, clr, saturate), instantiated NUM_CH times.
- Pending/ovf logic and FSM stay in the top module.

Test Plan:
- Reset, irq_en=8'hFF, r_edge[0] pulse at cycle k -> pending=8'h01 after k, irq=1 after k+2, evt_cnt ch0=1, ovf=0.
- Second r_edge[0] pulse while pending[0]=1 -> ovf=8'h01, evt_cnt ch0=2; clr_valid with clr_mask=8'h01 -> pending=0, ovf=0, irq drops next cycle, stays 0 for 16 cycles.
- irq_en=8'h00, f_edge[2] pulse -> pending=8'h40, irq stays 0; then set irq_en=8'h40 -> irq=1 two cycles later.
- Same-cycle f_edge[1] and clr_valid with clr_mask=8'h20 while pending[5]=1 -> pending[5] stays 1, ovf[5]=0, irq remains 1.
- CNT_W=8: 300 r_edge[3] pulses -> evt_cnt ch3=255; cnt_clr[3] together with r_edge[3] and f_edge[3] -> evt_cnt ch3=2.
- HOLDOFF_CYCLES=16: clear all pending, then a new event at holdoff cycle 3 -> irq stays 0 until holdoff ends, re-asserts exactly 1 cycle after HOLDOFF exits; rst_n low mid-HOLDOFF -> all outputs 0 immediately.
